tmr_input_voter: RTL

TMR_INPUT_VOTER -- requirements
Module: tmr_input_voter

---
 rtl/tmr_input_voter.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/tmr_input_voter.sv
// tmr_input_voter
// Votes three redundant, asynchronous reset-release copies into one reset.
// Each lane is synchronized, a 2-of-3 majority drives voted_resetn, and a lane
// that disagrees with the majority for PERSIST consecutive cycles is latched
// as faulty. Two or more faulty lanes put the voter into FAILED, where the
// voted reset is held asserted (0) as the safe state.
//
// Ports
//   clk          system clock, all state on the rising edge
//   rst_n        asynchronous active-low reset
//   lane_in      three redundant resetn copies (asynchronous to clk)
//   fault_clr    synchronous pulse clearing flags, run counters and fault_count
//   voted_resetn registered majority, forced 0 in FAILED
//   disagreement registered "synchronized lanes not all equal"
//   fault_flags  sticky per-lane fault flags (bit i = lane i)
//   fault_count  saturating number of flag assertions since reset/clear
//   voter_state  00 NORMAL, 01 DEGRADED, 10 FAILED
module tmr_input_voter #(
  parameter int SYNC_STAGES = 2,
  parameter int PERSIST     = 4,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [2:0]       lane_in,
  input  logic             fault_clr,
  output logic             voted_resetn,
  output logic             disagreement,
  output logic [2:0]       fault_flags,
  output logic [CNT_W-1:0] fault_count,
  output logic [1:0]       voter_state
);

  typedef enum logic [1:0] {
    ST_NORMAL   = 2'b00,
    ST_DEGRADED = 2'b01,
    ST_FAILED   = 2'b10
  } state_e;

  // Run counters are sized for the largest legal PERSIST (255).
  localparam int                MC_W       = 8;
  localparam logic [MC_W-1:0]   PERSIST_C  = MC_W'(PERSIST);
  localparam logic [MC_W-1:0]   PERSIST_M1 = MC_W'(PERSIST - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX    = {CNT_W{1'b1}};

  // Number of set bits in a 3-bit vector.
  function automatic logic [1:0] pop3(input logic [2:0] v);
    return {1'b0, v[0]} + {1'b0, v[1]} + {1'b0, v[2]};
  endfunction

  logic [2:0]       sync_r [SYNC_STAGES];
  logic [MC_W-1:0]  mc_r [3];
  logic [MC_W-1:0]  mc_next_s [3];
  logic [2:0]       lanes_s;
  logic             maj_s;
  logic             disagree_s;
  logic [2:0]       mismatch_s;
  logic [2:0]       flags_next_s;
  logic [2:0]       rise_s;
  logic [CNT_W+1:0] sum_s;
  logic [CNT_W-1:0] count_next_s;
  state_e           state_next_s;
  logic             voted_r;
  logic             disagree_r;
  logic [2:0]       flags_r;
  logic [CNT_W-1:0] count_r;
  state_e           state_r;

  // Per-lane synchronizer chains; stage 0 captures the asynchronous inputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < SYNC_STAGES; k++) begin
        sync_r[k] <= 3'b000;
      end
    end else begin
      sync_r[0] <= lane_in;
      for (int k = 1; k < SYNC_STAGES; k++) begin
        sync_r[k] <= sync_r[k-1];
      end
    end
  end

  assign lanes_s = sync_r[SYNC_STAGES-1];

  // Majority, disagreement and next-state of the fault tracking.
  always_comb begin
    maj_s      = (lanes_s[0] & lanes_s[1]) | (lanes_s[0] & lanes_s[2]) |
                 (lanes_s[1] & lanes_s[2]);
    disagree_s = (lanes_s[0] != lanes_s[1]) | (lanes_s[1] != lanes_s[2]);
    mismatch_s = lanes_s ^ {3{maj_s}};
    flags_next_s = flags_r;
    for (int i = 0; i < 3; i++) begin
      mc_next_s[i] = {MC_W{1'b0}};
      if (fault_clr) begin
        mc_next_s[i] = {MC_W{1'b0}};
      end else if (mismatch_s[i]) begin
        // The PERSIST-th consecutive mismatch latches the flag; the counter
        // parks at PERSIST so a long run cannot trigger again.
        if (mc_r[i] == PERSIST_M1) begin
          flags_next_s[i] = 1'b1;
        end else begin
          flags_next_s[i] = flags_r[i];
        end
        if (mc_r[i] == PERSIST_C) begin
          mc_next_s[i] = PERSIST_C;
        end else begin
          mc_next_s[i] = mc_r[i] + {{(MC_W-1){1'b0}}, 1'b1};
        end
      end else begin
        mc_next_s[i] = {MC_W{1'b0}};
      end
    end
    if (fault_clr) begin
      flags_next_s = 3'b000;
    end else begin
      flags_next_s = flags_next_s;
    end
    rise_s = flags_next_s & ~flags_r;
    sum_s  = {2'b00, count_r} + {{CNT_W{1'b0}}, pop3(rise_s)};
    if (fault_clr) begin
      count_next_s = {CNT_W{1'b0}};
    end else if (sum_s > {2'b00, CNT_MAX}) begin
      count_next_s = CNT_MAX;
    end else begin
      count_next_s = sum_s[CNT_W-1:0];
    end
    case (pop3(flags_next_s))
      2'd0:    state_next_s = ST_NORMAL;
      2'd1:    state_next_s = ST_DEGRADED;
      default: state_next_s = ST_FAILED;
    endcase
  end

  // Run counters per lane.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) begin
        mc_r[i] <= {MC_W{1'b0}};
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        mc_r[i] <= mc_next_s[i];
      end
    end
  end

  // Output registers; the voted reset uses the state being entered so that
  // it drops on the same edge the voter becomes FAILED.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      voted_r    <= 1'b0;
      disagree_r <= 1'b0;
      flags_r    <= 3'b000;
      count_r    <= {CNT_W{1'b0}};
      state_r    <= ST_NORMAL;
    end else begin
      voted_r    <= maj_s & (state_next_s != ST_FAILED);
      disagree_r <= disagree_s;
      flags_r    <= flags_next_s;
      count_r    <= count_next_s;
      state_r    <= state_next_s;
    end
  end

  assign voted_resetn = voted_r;
  assign disagreement = disagree_r;
  assign fault_flags  = flags_r;
  assign fault_count  = count_r;
  assign voter_state  = state_r;

endmodule
